// File: rtl/aes_pkg.sv
// Shared AES definitions: round constants, key-scheduler state encoding and S-box direction.
package aes_pkg;

  localparam logic [3:0] AES_NR   = 4'd10;
  localparam logic       SBOX_FWD = 1'b0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    STREAM = 2'd2
  } dkey_state_e;

  // Rcon word for rounds 1..10; any other index yields zero.
  function automatic logic [31:0] rcon(input logic [3:0] rnd);
    logic [7:0] b;
    case (rnd)
      4'd1:    b = 8'h01;
      4'd2:    b = 8'h02;
      4'd3:    b = 8'h04;
      4'd4:    b = 8'h08;
      4'd5:    b = 8'h10;
      4'd6:    b = 8'h20;
      4'd7:    b = 8'h40;
      4'd8:    b = 8'h80;
      4'd9:    b = 8'h1b;
      4'd10:   b = 8'h36;
      default: b = 8'h00;
    endcase
    return {b, 24'h000000};
  endfunction

endpackage

// File: rtl/sub_word.sv
// Four parallel AES S-boxes on a 32-bit word; i_inv selects the inverse S-box.
module sub_word (
  input  logic [31:0] i_word,
  input  logic        i_inv,
  output logic [31:0] o_word
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0).
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
    logic [7:0] v;
    v = gf_inv(b);
    return v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] s);
    return gf_inv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
  endfunction

  always_comb begin
    o_word = '0;
    for (int i = 0; i < 4; i++) begin
      o_word[8*i +: 8] = i_inv ? sbox_inv(i_word[8*i +: 8]) : sbox_fwd(i_word[8*i +: 8]);
    end
  end

endmodule

// File: rtl/aes_dec_key_gen.sv
// AES-128 decryption key scheduler: expands forward to round 10, then streams keys 10..0.
// Optional round-10 key cache enabled by defining AES_DKEY_CACHE_EN.
module aes_dec_key_gen
  import aes_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         start_i,
  input  logic [127:0] key_i,
  input  logic         rkey_ready_i,
  output logic [127:0] rkey_o,
  output logic         rkey_valid_o,
  output logic [3:0]   round_o,
  output logic         busy_o,
  output logic         done_o
);

  dkey_state_e  r_state;
  dkey_state_e  w_state_nxt;
  logic [127:0] r_key;
  logic [3:0]   r_round;
  logic         r_done;
  logic [31:0]  w_sw_in;
  logic [31:0]  w_sw_out;
  logic [127:0] w_fwd_key;
  logic [127:0] w_prev_key;
  logic         w_hit;
  logic [127:0] w_hit_key;

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [127:0] fwd_key_round(input logic [127:0] k,
                                                 input logic [31:0]  sw,
                                                 input logic [31:0]  rc);
    logic [31:0] w4, w5, w6, w7;
    w4 = k[127:96] ^ sw ^ rc;
    w5 = k[95:64] ^ w4;
    w6 = k[63:32] ^ w5;
    w7 = k[31:0] ^ w6;
    return {w4, w5, w6, w7};
  endfunction

  // sw must be SubWord(RotWord(a3 ^ a2)), i.e. of the recovered b3.
  function automatic logic [127:0] inv_key_round(input logic [127:0] k,
                                                 input logic [31:0]  sw,
                                                 input logic [31:0]  rc);
    logic [31:0] b0, b1, b2, b3;
    b3 = k[31:0] ^ k[63:32];
    b2 = k[63:32] ^ k[95:64];
    b1 = k[95:64] ^ k[127:96];
    b0 = k[127:96] ^ sw ^ rc;
    return {b0, b1, b2, b3};
  endfunction

  assign w_sw_in = (r_state == STREAM) ? rot_word(r_key[31:0] ^ r_key[63:32])
                                       : rot_word(r_key[31:0]);

  sub_word u_sub_word (
    .i_word (w_sw_in),
    .i_inv  (SBOX_FWD),
    .o_word (w_sw_out)
  );

  assign w_fwd_key  = fwd_key_round(r_key, w_sw_out, rcon(r_round + 4'd1));
  assign w_prev_key = inv_key_round(r_key, w_sw_out, rcon(r_round));

`ifdef AES_DKEY_CACHE_EN
  logic         r_cache_vld;
  logic [127:0] r_cache_key;
  logic [127:0] r_cache_rk10;
  logic [127:0] r_pend_key;

  assign w_hit     = r_cache_vld && (key_i == r_cache_key);
  assign w_hit_key = r_cache_rk10;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cache_vld <= 1'b0;
    end else if (r_state == EXPAND && r_round == AES_NR - 4'd1) begin
      r_cache_vld <= 1'b1;
    end
  end

  // Cache contents only matter once r_cache_vld is set, so they carry no reset.
  always_ff @(posedge clk_i) begin
    if (r_state == IDLE && start_i) r_pend_key <= key_i;
    if (r_state == EXPAND && r_round == AES_NR - 4'd1) begin
      r_cache_key  <= r_pend_key;
      r_cache_rk10 <= w_fwd_key;
    end
  end
`else
  assign w_hit     = 1'b0;
  assign w_hit_key = '0;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start_i) w_state_nxt = w_hit ? STREAM : EXPAND;
      EXPAND:  if (r_round == AES_NR - 4'd1) w_state_nxt = STREAM;
      STREAM:  if (rkey_ready_i && r_round == 4'd0) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_key   <= '0;
      r_round <= 4'd0;
      r_done  <= 1'b0;
    end else begin
      r_done <= (r_state == STREAM) && rkey_ready_i && (r_round == 4'd0);
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_key   <= w_hit ? w_hit_key : key_i;
            r_round <= w_hit ? AES_NR : 4'd0;
          end
        end
        EXPAND: begin
          r_key   <= w_fwd_key;
          r_round <= r_round + 4'd1;
        end
        STREAM: begin
          if (rkey_ready_i && r_round != 4'd0) begin
            r_key   <= w_prev_key;
            r_round <= r_round - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rkey_o       = r_key;
    round_o      = r_round;
    rkey_valid_o = (r_state == STREAM);
    busy_o       = (r_state != IDLE);
    done_o       = r_done;
  end

endmodule

// File: tb/tb_aes_dec_key_gen.sv
// Directed bench for aes_dec_key_gen using FIPS-197 key schedules.
module tb_aes_dec_key_gen;

  logic         clk_i = 1'b0;
  logic         rst_n_i = 1'b0;
  logic         start_i = 1'b0;
  logic [127:0] key_i = '0;
  logic         rkey_ready_i = 1'b0;
  logic [127:0] rkey_o;
  logic         rkey_valid_o;
  logic [3:0]   round_o;
  logic         busy_o;
  logic         done_o;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] K_FIPS    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K_SEQ     = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K_SEQ_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] FIPS_RK [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };
`ifdef AES_DKEY_CACHE_EN
  localparam int REPEAT_LAT = 1;
`else
  localparam int REPEAT_LAT = 11;
`endif

  always #5 clk_i = ~clk_i;

  aes_dec_key_gen dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .start_i      (start_i),
    .key_i        (key_i),
    .rkey_ready_i (rkey_ready_i),
    .rkey_o       (rkey_o),
    .rkey_valid_o (rkey_valid_o),
    .round_o      (round_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  logic [127:0] cap_key   [0:10];
  logic [3:0]   cap_round [0:10];
  int           cap_n, cap_lat, cap_done_cyc, cap_last_acc, cap_stall_bad;
  logic         cap_busy_at_done, cap_timeout;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Issues a start in the current cycle and records the stream until done_o is seen.
  task automatic collect(input logic [127:0] k, input bit rnd_rdy, input bit inject);
    logic         prev_stall;
    logic [127:0] prev_key;
    logic [3:0]   prev_round;
    prev_stall = 1'b0;
    prev_key = '0;
    prev_round = '0;
    cap_n = 0; cap_lat = -1; cap_done_cyc = -1; cap_last_acc = -1;
    cap_stall_bad = 0; cap_busy_at_done = 1'b1; cap_timeout = 1'b1;
    start_i = 1'b1;
    key_i = k;
    rkey_ready_i = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    for (int c = 1; c <= 400; c++) begin
      step();
      start_i = inject && (c == 5 || c == REPEAT_LAT + 3);
      key_i = inject ? K_SEQ : ~k;
      if (done_o) begin
        cap_done_cyc = c;
        cap_busy_at_done = busy_o;
        cap_timeout = 1'b0;
        start_i = 1'b0;
        break;
      end
      rkey_ready_i = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rkey_valid_o) begin
        if (cap_lat < 0) cap_lat = c;
        if (prev_stall && (rkey_o !== prev_key || round_o !== prev_round)) cap_stall_bad++;
        if (rkey_ready_i && cap_n < 11) begin
          cap_key[cap_n] = rkey_o;
          cap_round[cap_n] = round_o;
          cap_n++;
          cap_last_acc = c;
        end
        prev_stall = !rkey_ready_i;
        prev_key = rkey_o;
        prev_round = round_o;
      end else begin
        prev_stall = 1'b0;
      end
    end
    start_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0;
    start_i = 1'b1;
    key_i = K_FIPS;
    repeat (3) step();
    checks++; if (rkey_o !== '0) begin errors++; $display("FAIL reset_rkey: got %h, expected 0", rkey_o); end
    checks++; if (rkey_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, expected 0", rkey_valid_o); end
    checks++; if (round_o !== 4'd0) begin errors++; $display("FAIL reset_round: got %0d, expected 0", round_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy_o); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, expected 0", done_o); end
    start_i = 1'b0;
    rst_n_i = 1'b1;
    step();
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b, expected 0", busy_o); end
  endtask

  task automatic test_fips();
    int dcnt;
    collect(K_FIPS, 1'b0, 1'b0);
    checks++; if (cap_timeout) begin errors++; $display("FAIL fips_timeout: got no done_o, expected done_o"); end
    checks++; if (cap_lat !== 11) begin errors++; $display("FAIL fips_latency: got %0d, expected 11", cap_lat); end
    checks++; if (cap_n !== 11) begin errors++; $display("FAIL fips_count: got %0d, expected 11", cap_n); end
    for (int i = 0; i < 11; i++) begin
      checks++; if (cap_key[i] !== FIPS_RK[10-i]) begin errors++; $display("FAIL fips_key%0d: got %h, expected %h", 10-i, cap_key[i], FIPS_RK[10-i]); end
      checks++; if (cap_round[i] !== 4'(10-i)) begin errors++; $display("FAIL fips_round%0d: got %0d, expected %0d", i, cap_round[i], 10-i); end
    end
    checks++; if (cap_done_cyc !== 22) begin errors++; $display("FAIL fips_done_cycle: got %0d, expected 22", cap_done_cyc); end
    checks++; if (cap_last_acc !== 21) begin errors++; $display("FAIL fips_last_accept: got %0d, expected 21", cap_last_acc); end
    checks++; if (cap_busy_at_done !== 1'b0) begin errors++; $display("FAIL fips_busy_at_done: got %b, expected 0", cap_busy_at_done); end
    dcnt = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (done_o) dcnt++;
    end
    checks++; if (dcnt !== 0) begin errors++; $display("FAIL fips_done_once: got %0d extra pulses, expected 0", dcnt); end
  endtask

  task automatic test_backpressure();
    collect(K_FIPS, 1'b1, 1'b0);
    checks++; if (cap_timeout) begin errors++; $display("FAIL bp_timeout: got no done_o, expected done_o"); end
    checks++; if (cap_lat !== REPEAT_LAT) begin errors++; $display("FAIL bp_latency: got %0d, expected %0d", cap_lat, REPEAT_LAT); end
    checks++; if (cap_n !== 11) begin errors++; $display("FAIL bp_count: got %0d, expected 11", cap_n); end
    for (int i = 0; i < 11; i++) begin
      checks++; if (cap_key[i] !== FIPS_RK[10-i] || cap_round[i] !== 4'(10-i)) begin errors++; $display("FAIL bp_key%0d: got %h/%0d, expected %h/%0d", 10-i, cap_key[i], cap_round[i], FIPS_RK[10-i], 10-i); end
    end
    checks++; if (cap_stall_bad !== 0) begin errors++; $display("FAIL bp_stall_stable: got %0d changes, expected 0", cap_stall_bad); end
    checks++; if (cap_done_cyc !== cap_last_acc + 1) begin errors++; $display("FAIL bp_done_cycle: got %0d, expected %0d", cap_done_cyc, cap_last_acc + 1); end
  endtask

  task automatic test_start_ignored();
    collect(K_FIPS, 1'b0, 1'b1);
    checks++; if (cap_timeout) begin errors++; $display("FAIL ign_timeout: got no done_o, expected done_o"); end
    checks++; if (cap_lat !== REPEAT_LAT) begin errors++; $display("FAIL ign_latency: got %0d, expected %0d", cap_lat, REPEAT_LAT); end
    checks++; if (cap_done_cyc !== REPEAT_LAT + 11) begin errors++; $display("FAIL ign_done_cycle: got %0d, expected %0d", cap_done_cyc, REPEAT_LAT + 11); end
    for (int i = 0; i < 11; i++) begin
      checks++; if (cap_key[i] !== FIPS_RK[10-i] || cap_round[i] !== 4'(10-i)) begin errors++; $display("FAIL ign_key%0d: got %h/%0d, expected %h/%0d", 10-i, cap_key[i], cap_round[i], FIPS_RK[10-i], 10-i); end
    end
  endtask

  task automatic test_back_to_back();
    int dcnt;
    collect(K_FIPS, 1'b0, 1'b0);
    checks++; if (cap_timeout) begin errors++; $display("FAIL b2b_first_timeout: got no done_o, expected done_o"); end
    collect(K_SEQ, 1'b0, 1'b0);
    checks++; if (cap_timeout) begin errors++; $display("FAIL b2b_timeout: got no done_o, expected done_o"); end
    checks++; if (cap_lat !== 11) begin errors++; $display("FAIL b2b_latency: got %0d, expected 11", cap_lat); end
    checks++; if (cap_key[0] !== K_SEQ_R10) begin errors++; $display("FAIL b2b_key10: got %h, expected %h", cap_key[0], K_SEQ_R10); end
    checks++; if (cap_round[0] !== 4'd10) begin errors++; $display("FAIL b2b_round10: got %0d, expected 10", cap_round[0]); end
    checks++; if (cap_key[10] !== K_SEQ) begin errors++; $display("FAIL b2b_key0: got %h, expected %h", cap_key[10], K_SEQ); end
    checks++; if (cap_done_cyc !== 22) begin errors++; $display("FAIL b2b_done_cycle: got %0d, expected 22", cap_done_cyc); end
    dcnt = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (done_o || busy_o) dcnt++;
    end
    checks++; if (dcnt !== 0) begin errors++; $display("FAIL b2b_quiet_after: got %0d active cycles, expected 0", dcnt); end
  endtask

  task automatic test_abort();
    int dcnt;
    start_i = 1'b1;
    key_i = K_FIPS;
    rkey_ready_i = 1'b1;
    step();
    start_i = 1'b0;
    repeat (4) step();
    checks++; if (busy_o !== 1'b1 || round_o !== 4'd4) begin errors++; $display("FAIL abort_pre_state: got busy=%b round=%0d, expected busy=1 round=4", busy_o, round_o); end
    rst_n_i = 1'b0;
    #1;
    checks++; if ({rkey_o, rkey_valid_o, round_o, busy_o, done_o} !== '0) begin errors++; $display("FAIL abort_outputs: got %h %b %0d %b %b, expected all 0", rkey_o, rkey_valid_o, round_o, busy_o, done_o); end
    dcnt = 0;
    for (int i = 0; i < 2; i++) begin
      step();
      if (done_o || busy_o || rkey_valid_o || rkey_o != '0) dcnt++;
    end
    rst_n_i = 1'b1;
    step();
    if (done_o || busy_o) dcnt++;
    checks++; if (dcnt !== 0) begin errors++; $display("FAIL abort_quiet: got %0d active cycles, expected 0", dcnt); end
    collect(K_FIPS, 1'b0, 1'b0);
    checks++; if (cap_timeout) begin errors++; $display("FAIL abort_rerun_timeout: got no done_o, expected done_o"); end
    checks++; if (cap_lat !== 11) begin errors++; $display("FAIL abort_rerun_latency: got %0d, expected 11", cap_lat); end
    checks++; if (cap_key[0] !== FIPS_RK[10]) begin errors++; $display("FAIL abort_rerun_key10: got %h, expected %h", cap_key[0], FIPS_RK[10]); end
    checks++; if (cap_key[1] !== FIPS_RK[9]) begin errors++; $display("FAIL abort_rerun_key9: got %h, expected %h", cap_key[1], FIPS_RK[9]); end
    checks++; if (cap_key[10] !== K_FIPS) begin errors++; $display("FAIL abort_rerun_key0: got %h, expected %h", cap_key[10], K_FIPS); end
    checks++; if (cap_done_cyc !== 22) begin errors++; $display("FAIL abort_rerun_done: got %0d, expected 22", cap_done_cyc); end
  endtask

`ifdef AES_DKEY_CACHE_EN
  task automatic test_cache();
    collect(K_FIPS, 1'b0, 1'b0);
    checks++; if (cap_lat !== 1) begin errors++; $display("FAIL cache_hit_latency: got %0d, expected 1", cap_lat); end
    checks++; if (cap_key[0] !== FIPS_RK[10]) begin errors++; $display("FAIL cache_hit_key10: got %h, expected %h", cap_key[0], FIPS_RK[10]); end
    checks++; if (cap_key[10] !== K_FIPS) begin errors++; $display("FAIL cache_hit_key0: got %h, expected %h", cap_key[10], K_FIPS); end
    collect(K_SEQ, 1'b0, 1'b0);
    checks++; if (cap_lat !== 11) begin errors++; $display("FAIL cache_miss_latency: got %0d, expected 11", cap_lat); end
    checks++; if (cap_key[0] !== K_SEQ_R10) begin errors++; $display("FAIL cache_miss_key10: got %h, expected %h", cap_key[0], K_SEQ_R10); end
    rst_n_i = 1'b0;
    step();
    rst_n_i = 1'b1;
    step();
    collect(K_SEQ, 1'b0, 1'b0);
    checks++; if (cap_lat !== 11) begin errors++; $display("FAIL cache_after_reset_latency: got %0d, expected 11", cap_lat); end
    checks++; if (cap_key[0] !== K_SEQ_R10) begin errors++; $display("FAIL cache_after_reset_key10: got %h, expected %h", cap_key[0], K_SEQ_R10); end
  endtask
`endif

  initial begin
    test_reset();
    test_fips();
    test_backpressure();
    test_start_ignored();
    test_back_to_back();
    test_abort();
`ifdef AES_DKEY_CACHE_EN
    test_cache();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
